mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that gives core firmware a byte-stream output channel to the simulation host or board console, running at the 25 MHz core clock. The core's data-memory path writes bytes into a small FIFO. An 8N1 serializer drains the FIFO onto uart_tx at a programmable bit period. Sits on the core's MMIO decode alongside data memory and is instantiated inside top.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
DIV_W, 16, width of the baud divisor register.
DEFAULT_DIV, 217, reset divisor value (25 MHz / 115200).

Ports:
clock  in  1  core clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
mmio_we  in  1  write strobe, one cycle per access.
mmio_re  in  1  read strobe, one cycle per access.
mmio_addr  in  4  byte offset within block; bits[1:0] ignored.
mmio_wdata  in  32  write data.
mmio_rdata  out  32  read data, registered, valid the cycle after mmio_re.
uart_tx  out  1  serial line; idles high.
irq_empty  out  1  high while FIFO empty and serializer idle.

Behaviour:
- Register map:
  - 0x0 TXDATA (W): push wdata[7:0].
  - 0x4 STATUS (R): [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), other bits 0.
  - 0x8 DIV (R/W): wdata[DIV_W-1:0].
  - Other offsets: reads return 0; writes are ignored.
- Reset (async): uart_tx=1, mmio_rdata=0, irq_empty=1, FIFO emptied, overflow=0, DIV=DEFAULT_DIV, FSM=IDLE. Reset mid-frame aborts the frame immediately; the line returns high.
- mmio_we and mmio_re in the same cycle: both are honoured.
- Reading STATUS returns the pre-clear value and clears overflow on the same edge.
- Push to TXDATA while full:
  - Data is dropped and overflow is set.
  - "Full" is evaluated before any same-cycle pop; a push is rejected even if the serializer pops in that cycle.
- Bit period is max(DIV,1) cycles; DIV=0 behaves as 1.
  - A DIV write takes effect at the next bit boundary; the current bit completes with the old period.
- FSM states and transitions:
  - IDLE: if FIFO is non-empty, pop into the shift register, drive uart_tx=0, go to START.
  - START: hold 0 for one bit period, then go to DATA.
  - DATA: 8 bits, LSB first, each one bit period; bit counter 0..7, then go to STOP.
  - STOP: hold 1 for one bit period. At the end of the period, if FIFO is non-empty, pop and go to START directly (no idle gap); otherwise go to IDLE.
- Latency: push accepted at edge E into an empty FIFO with FSM in IDLE → pop at edge E+1, and uart_tx falls after edge E+1.
- Frame length is exactly 10 × period cycles. Back-to-back frames are gapless.
- FIFO: pointers wrap modulo FIFO_DEPTH, with a count of width log2(FIFO_DEPTH)+1. Simultaneous push and pop while not full leaves count unchanged.
- uart_tx is driven from a flop (glitch-free).
- irq_empty is registered and matches STATUS[1] & ~STATUS[2].

Decomposition:
- defines.vh carries:
  - Register offsets UART_TXDATA/UART_STATUS/UART_DIV.
  - STATUS bit indices.
  - FSM state encodings (2-bit: IDLE, START, DATA, STOP).
  - The MMIO base address of the block, for top's decode.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count; async active-high reset). It is reusable for a future RX path.

Test Plan:
- Reset then idle 50 cycles → uart_tx=1; STATUS read returns 0x2; irq_empty=1; DIV read returns 217.
- DIV=4, write 0x55 → uart_tx falls 1 cycle after the write edge. Line sequence: 0 ×4, then 1,0,1,0,1,0,1,0 ×4 each, then 1 ×4. Total 40 cycles; busy=1 throughout, then irq_empty=1.
- DIV=2, write 0xA3 and 0x0F on consecutive cycles → two frames, 20 cycles each, with no idle cycle between the first stop bit and the second start bit. Decoded bytes are 0xA3 then 0x0F.
- DIV=8, 9 pushes back-to-back with FIFO_DEPTH=8 → one byte popped at the second push edge, so all 9 are accepted and overflow=0. A 10th push before the frame ends sets full-drop: STATUS=0x9/0xD with overflow set. The first STATUS read shows bit3=1, the second read shows bit3=0. Exactly 9 frames are emitted.
- DIV=3, write 0xFF, and at cycle 10 of the frame assert reset for 2 cycles → uart_tx=1 asynchronously, FIFO empty, DIV reads 217, and no further frame is emitted.
- DIV=0 and write 0x01 → 10-cycle frame. Then write DIV=5 mid-frame during bit 3 → bit 3 stays 1 cycle long, and subsequent bits are 5 cycles long.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer states and the block's base address.
package mmio_uart_tx_pkg;

  // Byte offsets within the block
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  // STATUS register bit indices
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  // Where the SoC top decodes this block on the data-memory path
  localparam logic [31:0] UART_BASE = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output, shared by the TX path
// and a future RX path. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: firmware pushes bytes into a FIFO, an 8N1 serializer
// drains them onto uart_tx with a programmable bit period of max(DIV,1) cycles.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 217
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [3:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        uart_tx,
  output logic        irq_empty
);

  logic [3:0]                    reg_off;
  logic                          sel_txdata, sel_status, sel_div;
  logic                          push, push_ok, pop;
  logic                          fifo_full, fifo_empty;
  logic [7:0]                    fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [DIV_W-1:0]              div_q, div_next, bit_reload;
  logic                          ovf_q;
  logic [31:0]                   status_word;
  tx_state_e                     state_q;
  logic [DIV_W-1:0]              cyc_q;
  logic [2:0]                    bit_idx;
  logic [7:0]                    shreg;
  logic                          bit_end;
  logic                          unused_bits;

  assign reg_off    = {mmio_addr[3:2], 2'b00};
  assign sel_txdata = (reg_off == UART_TXDATA);
  assign sel_status = (reg_off == UART_STATUS);
  assign sel_div    = (reg_off == UART_DIV);

  assign push    = mmio_we & sel_txdata;
  assign push_ok = push & ~fifo_full;

  // A DIV write landing on a bit boundary already governs the bit that starts there
  assign div_next   = (mmio_we & sel_div) ? mmio_wdata[DIV_W-1:0] : div_q;
  assign bit_reload = (div_next == '0) ? '0 : div_next - DIV_W'(1);
  assign bit_end    = (cyc_q == '0);

  assign pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  assign unused_bits = &{1'b0, mmio_addr[1:0], mmio_wdata, fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (mmio_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    status_word          = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = (state_q != IDLE);
    status_word[ST_OVF]   = ovf_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      ovf_q      <= 1'b0;
      mmio_rdata <= '0;
    end else begin
      div_q <= div_next;
      // A rejected push in the same cycle as a STATUS read must not be lost
      ovf_q <= (ovf_q & ~(mmio_re & sel_status)) | (push & fifo_full);
      if (mmio_re) begin
        if (sel_status)   mmio_rdata <= status_word;
        else if (sel_div) mmio_rdata <= 32'(div_q);
        else              mmio_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      uart_tx   <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shreg     <= fifo_dout;
            uart_tx   <= 1'b0;
            cyc_q     <= bit_reload;
            state_q   <= START;
            irq_empty <= 1'b0;
          end else begin
            uart_tx   <= 1'b1;
            irq_empty <= ~push_ok;
          end
        end
        START: begin
          irq_empty <= 1'b0;
          if (bit_end) begin
            uart_tx <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            cyc_q   <= bit_reload;
            state_q <= DATA;
          end else begin
            cyc_q <= cyc_q - DIV_W'(1);
          end
        end
        DATA: begin
          irq_empty <= 1'b0;
          if (bit_end) begin
            cyc_q <= bit_reload;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state_q <= STOP;
            end else begin
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cyc_q <= cyc_q - DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              // Back-to-back frame: start bit follows the stop bit with no idle gap
              shreg     <= fifo_dout;
              uart_tx   <= 1'b0;
              cyc_q     <= bit_reload;
              state_q   <= START;
              irq_empty <= 1'b0;
            end else begin
              uart_tx   <= 1'b1;
              state_q   <= IDLE;
              irq_empty <= ~push_ok;
            end
          end else begin
            cyc_q     <= cyc_q - DIV_W'(1);
            irq_empty <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a queue-based line model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mmio_uart_tx;

  localparam int         DEPTH  = 8;
  localparam int         HIST   = 32768;
  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_ST   = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mmio_we = 1'b0;
  logic        mmio_re = 1'b0;
  logic [3:0]  mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic        uart_tx;
  logic        irq_empty;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx dut (
    .clock      (clock),
    .reset      (reset),
    .mmio_we    (mmio_we),
    .mmio_re    (mmio_re),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .uart_tx    (uart_tx),
    .irq_empty  (irq_empty)
  );

  always #20 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Line is a queue of per-cycle levels; each bit's period is fixed when it starts.
  logic [7:0]  mq[$];
  logic        lq[$];
  logic        fb[$];
  logic [15:0] mdiv = 16'd217;
  logic        movf = 1'b0;
  logic        exp_tx = 1'b1;
  logic        exp_irq = 1'b1;
  logic        rd_pending = 1'b0;
  logic [31:0] exp_rdata = '0;
  int          mframes = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete(); lq.delete(); fb.delete();
      mdiv = 16'd217; movf = 1'b0; exp_tx = 1'b1; exp_irq = 1'b1;
      rd_pending = 1'b0; exp_rdata = '0;
    end else begin
      logic        pre_full, pre_empty, pre_busy, b;
      logic [1:0]  a;
      logic [15:0] ndiv;
      logic [7:0]  d;
      int          p;
      pre_full  = (mq.size() == DEPTH);
      pre_empty = (mq.size() == 0);
      pre_busy  = (lq.size() != 0);
      a         = mmio_addr[3:2];
      ndiv      = (mmio_we && a == 2'd2) ? mmio_wdata[15:0] : mdiv;
      p         = (ndiv == 0) ? 1 : int'(ndiv);
      rd_pending = mmio_re;
      if (mmio_re) begin
        if (a == 2'd1)      exp_rdata = {28'd0, movf, pre_busy, pre_empty, pre_full};
        else if (a == 2'd2) exp_rdata = {16'd0, mdiv};
        else                exp_rdata = '0;
      end
      if (lq.size() != 0) void'(lq.pop_front());
      if (lq.size() == 0) begin
        if (fb.size() != 0) begin
          b = fb.pop_front();
          repeat (p) lq.push_back(b);
        end else if (!pre_empty) begin
          d = mq.pop_front();
          for (int i = 0; i < 8; i++) fb.push_back(d[i]);
          fb.push_back(1'b1);
          repeat (p) lq.push_back(1'b0);
          mframes++;
        end
      end
      if (mmio_re && a == 2'd1) movf = 1'b0;
      if (mmio_we && a == 2'd0) begin
        if (pre_full) movf = 1'b1;
        else          mq.push_back(mmio_wdata[7:0]);
      end
      mdiv    = ndiv;
      exp_tx  = (lq.size() != 0) ? lq[0] : 1'b1;
      exp_irq = (mq.size() == 0) && (lq.size() == 0);
    end
  end

  // ---------------- compare process + line history ----------------
  logic tx_hist [0:HIST-1];
  int   cyc = 0;

  always @(negedge clock) begin
    if (cyc < HIST) tx_hist[cyc] = uart_tx;
    cyc++;
    check("uart_tx", uart_tx, exp_tx);
    check("irq_empty", irq_empty, exp_irq);
    if (rd_pending) check("mmio_rdata", mmio_rdata, exp_rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic int last();
    return cyc - 1;
  endfunction

  task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
    mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    tick();
    mmio_we = 1'b0;
  endtask

  task automatic mmio_read(input logic [3:0] a, output logic [31:0] d);
    mmio_re = 1'b1; mmio_addr = a;
    tick();
    mmio_re = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic wait_until(input int idx);
    int guard = 0;
    while (last() < idx && guard < 5000) begin tick(); guard++; end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (!(irq_empty === 1'b1 && uart_tx === 1'b1) && n < max) begin tick(); n++; end
    check(name, irq_empty, 1'b1);
  endtask

  function automatic logic [7:0] decode(input int s, input int p);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tx_hist[s + p * (i + 1) + p / 2];
    return r;
  endfunction

  initial begin : watchdog
    #10ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random tests ----------------
  initial begin
    logic [31:0] rd;
    logic [9:0]  f;
    int          w, s, mism, fr0, lows, highs;

    tick(); tick();
    reset = 1'b0;

    // Reset and idle
    repeat (50) tick();
    check("t1_tx_idle", uart_tx, 1'b1);
    check("t1_irq", irq_empty, 1'b1);
    mmio_read(A_ST, rd);  check("t1_status", rd, 32'h2);
    mmio_read(A_DIV, rd); check("t1_div", rd, 32'd217);

    // DIV=4, single 0x55 frame
    mmio_write(A_DIV, 32'd4);
    mmio_write(A_TX, 32'h55);
    w = last();
    repeat (3) tick();
    mmio_read(A_ST, rd); check("t2_status_busy", rd, 32'h6);
    wait_until(w + 45);
    check("t2_pre_fall", tx_hist[w], 1'b1);
    f = {1'b1, 8'h55, 1'b0};
    mism = 0;
    for (int k = 0; k < 40; k++) if (tx_hist[w + 1 + k] !== f[k / 4]) mism++;
    check("t2_frame_bits", mism, 0);
    check("t2_after_frame", tx_hist[w + 41], 1'b1);
    check("t2_irq_after", irq_empty, 1'b1);

    // DIV=2, two back-to-back frames
    mmio_write(A_DIV, 32'd2);
    mmio_write(A_TX, 32'hA3);
    w = last();
    mmio_write(A_TX, 32'h0F);
    wait_until(w + 45);
    check("t3_start1", tx_hist[w + 1], 1'b0);
    check("t3_byte1", decode(w + 1, 2), 8'hA3);
    check("t3_stop1", tx_hist[w + 20], 1'b1);
    check("t3_gapless", tx_hist[w + 21], 1'b0);
    check("t3_byte2", decode(w + 21, 2), 8'h0F);
    check("t3_idle", tx_hist[w + 41], 1'b1);

    // DIV=8, FIFO fill and overflow
    mmio_write(A_DIV, 32'd8);
    fr0 = mframes;
    for (int i = 0; i < 9; i++) mmio_write(A_TX, 32'h30 + i);
    mmio_read(A_ST, rd); check("t4_full_no_ovf", rd, 32'h5);
    mmio_write(A_TX, 32'h99);
    mmio_read(A_ST, rd); check("t4_ovf_set", rd, 32'hD);
    mmio_read(A_ST, rd); check("t4_ovf_cleared", rd, 32'h5);
    wait_idle("t4_drain", 1200);
    check("t4_frames", mframes - fr0, 9);

    // DIV=3, reset mid-frame at frame cycle 10
    mmio_write(A_DIV, 32'd3);
    mmio_write(A_TX, 32'hFF);
    w = last();
    wait_until(w + 10);
    check("t5_started", tx_hist[w + 2], 1'b0);
    fr0 = mframes;
    reset = 1'b1;
    #1;
    check("t5_tx_async", uart_tx, 1'b1);
    tick(); tick();
    reset = 1'b0;
    mmio_read(A_ST, rd);  check("t5_status", rd, 32'h2);
    mmio_read(A_DIV, rd); check("t5_div", rd, 32'd217);
    s = last();
    repeat (50) tick();
    lows = 0;
    for (int k = s; k <= last(); k++) if (tx_hist[k] !== 1'b1) lows++;
    check("t5_no_frame", lows, 0);
    check("t5_frames", mframes, fr0);

    // Reset during a start bit forces the line high immediately
    mmio_write(A_DIV, 32'd3);
    mmio_write(A_TX, 32'h00);
    tick(); tick();
    check("t5b_line_low", uart_tx, 1'b0);
    reset = 1'b1;
    #1;
    check("t5b_tx_async", uart_tx, 1'b1);
    tick();
    reset = 1'b0;

    // DIV=0 behaves as period 1
    mmio_write(A_DIV, 32'd0);
    mmio_write(A_TX, 32'h01);
    w = last();
    wait_until(w + 15);
    f = {1'b1, 8'h01, 1'b0};
    mism = 0;
    for (int k = 0; k < 10; k++) if (tx_hist[w + 1 + k] !== f[k]) mism++;
    check("t6_frame_div0", mism, 0);
    check("t6_idle_div0", tx_hist[w + 11], 1'b1);

    // DIV changed to 5 during data bit 3
    mmio_write(A_TX, 32'h01);
    w = last();
    repeat (5) tick();
    mmio_write(A_DIV, 32'd5);
    wait_until(w + 40);
    check("t6_start", tx_hist[w + 1], 1'b0);
    check("t6_bit0", tx_hist[w + 2], 1'b1);
    lows = 0;
    while (lows < 60 && tx_hist[w + 3 + lows] === 1'b0) lows++;
    check("t6_low_run", lows, 23);
    highs = 0;
    for (int k = w + 26; k <= w + 30; k++) if (tx_hist[k] === 1'b1) highs++;
    check("t6_stop_len", highs, 5);

    // Random traffic with small divisors
    mmio_write(A_DIV, 32'd1);
    for (int c = 0; c < 2500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      mmio_we    = (r < 15);
      mmio_re    = (r >= 10 && r < 25);
      mmio_addr  = 4'($urandom_range(0, 15));
      mmio_wdata = $urandom;
      if (mmio_addr[3:2] == 2'd2) mmio_wdata[15:0] = 16'($urandom_range(0, 3));
      tick();
    end
    mmio_we = 1'b0;
    mmio_re = 1'b0;
    wait_idle("rand_drain", 3000);
    mmio_read(A_ST, rd);
    check("rand_final_empty", rd[2:1], 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
